// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM state codes, edge count and
// the half-period calculation from the baud pre-select/select fields.
package spi_xfer_pkg;

    typedef logic [1:0] xfer_state_t;

    localparam xfer_state_t ST_IDLE = 2'd0;
    localparam xfer_state_t ST_LOAD = 2'd1;
    localparam xfer_state_t ST_XFER = 2'd2;
    localparam xfer_state_t ST_DONE = 2'd3;

    localparam int unsigned EDGES      = 16;
    localparam int unsigned HALF_MAX_W = 12;

    // (sppr+1) << spr at full width: 1..1024
    function automatic logic [HALF_MAX_W-1:0] calc_half(input logic [2:0] sppr,
                                                        input logic [2:0] spr);
        logic [HALF_MAX_W-1:0] base;
        base = HALF_MAX_W'(sppr) + HALF_MAX_W'(1);
        return base << spr;
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period generator: reloadable down-counter that emits a one-cycle tick every
// i_half cycles while enabled.
module spi_baud_gen
    import spi_xfer_pkg::*;
#(
    parameter int unsigned DIV_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_reload;
    logic             w_zero;

    assign w_reload = i_half - DIV_W'(1);
    assign w_zero   = (r_cnt == '0);
    assign o_tick   = i_en & ~i_restart & w_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= w_reload;
        end else if (i_en) begin
            r_cnt <= w_zero ? w_reload : r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: SS, SCLK, load/capture strobes and per-bit launch/sample pulses.
// Define SPI_XFER_B2B_EN to queue a start_i seen mid-frame and run frames back-to-back.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int unsigned DIV_W = 12
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       spe_i,
    input  logic       start_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    output logic       ss_o,
    output logic       sclk_o,
    output logic       send_data_o,
    output logic       receive_data_o,
    output logic       mosi_send_sclk_o,
    output logic       miso_receive_sclk_o,
    output logic       mosi_send_sclk0_o,
    output logic       miso_receive_sclk0_o,
    output logic       busy_o,
    output logic       done_o
);

    xfer_state_t      r_state;
    xfer_state_t      r_state_prev;
    xfer_state_t      w_state_d;
    logic [DIV_W-1:0] r_half;
    logic             r_cpol;
    logic             r_cpha;
    logic             r_sclk;
    logic [4:0]       r_edge;
    logic             r_setup_done;

    logic [DIV_W-1:0] w_half_live;
    logic [DIV_W-1:0] w_half_sel;
    logic             w_tick;
    logic             w_edge_tick;
    logic             w_last_edge;
    logic             w_first_xfer;
    logic             w_first_done;
    logic             w_again;
    logic             w_mosi;
    logic             w_miso;
    logic             w_alt;

    assign w_half_live = DIV_W'(calc_half(sppr_i, spr_i));
    // The counter is restarted during LOAD, before the live value has been latched.
    assign w_half_sel  = (r_state == ST_LOAD) ? w_half_live : r_half;

    spi_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .i_clk     (PCLK),
        .i_rst_n   (PRESET_n),
        .i_en      ((r_state == ST_XFER) || (r_state == ST_DONE)),
        .i_restart (r_state == ST_LOAD),
        .i_half    (w_half_sel),
        .o_tick    (w_tick)
    );

    // The first tick in XFER ends the setup phase; every later tick is an SCLK edge.
    assign w_edge_tick  = w_tick & r_setup_done & (r_state == ST_XFER);
    assign w_last_edge  = w_edge_tick & (r_edge == 5'(EDGES - 1));
    assign w_first_xfer = (r_state == ST_XFER) & (r_state_prev == ST_LOAD);
    assign w_first_done = (r_state == ST_DONE) & (r_state_prev == ST_XFER);

`ifdef SPI_XFER_B2B_EN
    logic r_pend;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_pend <= 1'b0;
        end else if (!spe_i) begin
            r_pend <= 1'b0;
        end else if (start_i && (r_state != ST_IDLE)) begin
            r_pend <= 1'b1;
        end else if (r_state == ST_LOAD) begin
            r_pend <= 1'b0;
        end
    end

    assign w_again = r_pend | start_i;
`else
    assign w_again = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_d = ST_LOAD;
            ST_LOAD: w_state_d = ST_XFER;
            ST_XFER: if (w_last_edge) w_state_d = ST_DONE;
            ST_DONE: if (w_tick) w_state_d = w_again ? ST_LOAD : ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
        if (!spe_i) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state      <= ST_IDLE;
            r_state_prev <= ST_IDLE;
        end else begin
            r_state      <= w_state_d;
            r_state_prev <= r_state;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_half <= '0;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_half <= w_half_live;
            r_cpol <= cpol_i;
            r_cpha <= cpha_i;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_sclk <= 1'b0;
        end else if (!spe_i || (r_state == ST_IDLE) || (r_state == ST_LOAD)) begin
            r_sclk <= cpol_i;
        end else if (w_edge_tick) begin
            r_sclk <= ~r_sclk;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_edge       <= '0;
            r_setup_done <= 1'b0;
        end else if (r_state != ST_XFER) begin
            r_edge       <= '0;
            r_setup_done <= 1'b0;
        end else if (w_tick) begin
            if (r_setup_done) begin
                r_edge <= r_edge + 5'd1;
            end else begin
                r_setup_done <= 1'b1;
            end
        end
    end

    // r_edge holds the count of edges already issued, so the current edge is r_edge+1.
    always_comb begin
        w_mosi = 1'b0;
        w_miso = 1'b0;
        if (r_cpha) begin
            w_mosi = w_edge_tick & ~r_edge[0];
            w_miso = w_edge_tick & r_edge[0];
        end else begin
            w_mosi = w_first_xfer | (w_edge_tick & r_edge[0] & (r_edge <= 5'(EDGES - 3)));
            w_miso = w_edge_tick & ~r_edge[0];
        end
    end

    assign w_alt = r_cpol ^ r_cpha;

    assign busy_o               = (r_state != ST_IDLE);
    assign ss_o                 = ~busy_o;
    assign sclk_o               = r_sclk;
    assign send_data_o          = (r_state == ST_LOAD);
    assign receive_data_o       = w_first_done & spe_i;
    assign done_o               = w_first_done & spe_i;
    assign mosi_send_sclk_o     = w_mosi & ~w_alt;
    assign miso_receive_sclk_o  = w_miso & ~w_alt;
    assign mosi_send_sclk0_o    = w_mosi & w_alt;
    assign miso_receive_sclk0_o = w_miso & w_alt;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: per-cycle expected output vectors come from a
// timing model of the frame and are compared by an independent negedge monitor.
module tb_spi_xfer_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESET_n;
    logic       spe_i, start_i, cpol_i, cpha_i;
    logic [2:0] sppr_i, spr_i;
    logic       ss_o, sclk_o, send_data_o, receive_data_o;
    logic       mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o, miso_receive_sclk0_o;
    logic       busy_o, done_o;

    spi_xfer_ctrl #(
        .DIV_W (12)
    ) dut (
        .PCLK                 (PCLK),
        .PRESET_n             (PRESET_n),
        .spe_i                (spe_i),
        .start_i              (start_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .ss_o                 (ss_o),
        .sclk_o               (sclk_o),
        .send_data_o          (send_data_o),
        .receive_data_o       (receive_data_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .miso_receive_sclk_o  (miso_receive_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .miso_receive_sclk0_o (miso_receive_sclk0_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // {ss, sclk, send, recv, mosi, miso, mosi0, miso0, busy, done}
    function automatic logic [9:0] mk(bit ss, bit sclk, bit send, bit recv, bit mosi, bit miso,
                                      bit alt, bit busy, bit done);
        return {ss, sclk, send, recv, mosi & ~alt, miso & ~alt, mosi & alt, miso & alt, busy, done};
    endfunction

    // Expected outputs at frame cycle t (t=1 is LOAD) derived from the frame timing rules.
    function automatic logic [9:0] frame_vec(int t, int h, bit cpol, bit cpha);
        int x, k, n_edges;
        bit mosi = 0, miso = 0, done = 0;
        n_edges = 0;
        if (t >= 2 && t <= 1 + 17 * h) begin
            x = t - 1;
            n_edges = (x - 1) / h - 1;
            if (n_edges < 0) n_edges = 0;
            if (x == 1 && !cpha) mosi = 1;
            if ((x % h) == 0 && (x / h) >= 2) begin
                k = x / h - 1;
                if ((k % 2) == 1) begin
                    if (cpha) mosi = 1; else miso = 1;
                end else begin
                    if (cpha) miso = 1; else if (k <= 14) mosi = 1;
                end
            end
        end else if (t > 1 + 17 * h) begin
            n_edges = 16;
            done = (t == 2 + 17 * h);
        end
        return mk(0, cpol ^ n_edges[0], t == 1, done, mosi, miso, cpol ^ cpha, 1, done);
    endfunction

    function automatic logic [9:0] rst_vec();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic push(int c, logic [9:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic push_idle(int c, bit sclk);
        push(c, mk(1, sclk, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    always @(negedge PCLK) begin
        exp_t       e;
        logic [9:0] act;
        act = {ss_o, sclk_o, send_data_o, receive_data_o, mosi_send_sclk_o, miso_receive_sclk_o,
               mosi_send_sclk0_o, miso_receive_sclk0_o, busy_o, done_o};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_check cyc=%0d got=none want=%b", e.cyc, e.vec);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (act !== e.vec) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%b want=%b (ss,sclk,send,recv,mosi,miso,mosi0,miso0,busy,done)",
                         cyc, act, e.vec);
            end
        end
    end

    // mode: 0 normal (config scrambled mid-frame), 1 spe drop after edge 7,
    //       2 reset mid-XFER, 3 extra start_i during XFER
    task automatic run_frame(int sppr, int spr, bit cpol, bit cpha, int mode);
        int h, len, c, stop_t, ev_t, end_t, frames;
        h   = (sppr + 1) << spr;
        len = 1 + 18 * h;
        step();
        push_idle(cyc, cpol_i);
        sppr_i  = 3'(sppr);
        spr_i   = 3'(spr);
        cpol_i  = cpol;
        cpha_i  = cpha;
        spe_i   = 1'b1;
        start_i = 1'b0;
        step();
        c = cyc;
        start_i = 1'b1;
        push_idle(c, cpol);
        stop_t = len;
        ev_t   = 0;
        frames = 1;
        if (mode == 1) stop_t = 8 * h + 2 + int'($urandom_range(h - 1, 0));
        if (mode == 2) stop_t = 2 + int'($urandom_range(17 * h - 1, 0));
        if (mode == 3) ev_t = 2 + int'($urandom_range(17 * h - 1, 0));
`ifdef SPI_XFER_B2B_EN
        if (mode == 3) frames = 2;
`endif
        if (mode == 2) begin
            for (int t = 1; t < stop_t; t++) push(c + t, frame_vec(t, h, cpol, cpha));
            for (int t = 0; t < 3; t++) push(c + stop_t + t, rst_vec());
            end_t = stop_t + 2;
        end else if (mode == 1) begin
            for (int t = 1; t <= stop_t; t++) push(c + t, frame_vec(t, h, cpol, cpha));
            push_idle(c + stop_t + 1, cpol);
            end_t = stop_t + 1;
        end else begin
            for (int f = 0; f < frames; f++)
                for (int t = 1; t <= len; t++) push(c + f * len + t, frame_vec(t, h, cpol, cpha));
            end_t = frames * len + 1;
            push_idle(c + end_t, cpol);
        end
        for (int t = 1; t <= end_t; t++) begin
            step();
            if (t == 1) start_i = 1'b0;
            if (mode == 0 && t == 2) begin
                sppr_i = 3'($urandom);
                spr_i  = 3'($urandom);
                cpol_i = 1'($urandom);
                cpha_i = 1'($urandom);
            end
            if (mode == 0 && t == len) begin
                sppr_i = 3'(sppr);
                spr_i  = 3'(spr);
                cpol_i = cpol;
                cpha_i = cpha;
            end
            if (mode == 1 && t == stop_t) spe_i = 1'b0;
            if (mode == 1 && t == stop_t + 1) spe_i = 1'b1;
            if (mode == 2 && t == stop_t) PRESET_n = 1'b0;
            if (mode == 2 && t == stop_t + 2) PRESET_n = 1'b1;
            if (mode == 3 && t == ev_t) start_i = 1'b1;
            if (mode == 3 && t == ev_t + 1) start_i = 1'b0;
        end
    endtask

    // Idle gap; a start_i with spe_i low must not launch a frame.
    task automatic gap();
        int n;
        n = int'($urandom_range(3, 0));
        for (int i = 0; i < n; i++) begin
            step();
            push_idle(cyc, cpol_i);
            if ($urandom_range(1, 0) == 1) begin
                spe_i   = 1'b0;
                start_i = 1'b1;
            end else begin
                spe_i   = 1'b1;
                start_i = 1'b0;
            end
        end
    endtask

    initial begin
        PRESET_n = 1'b0;
        spe_i    = 1'b0;
        start_i  = 1'b0;
        cpol_i   = 1'b0;
        cpha_i   = 1'b0;
        sppr_i   = 3'd0;
        spr_i    = 3'd0;
        step();
        push(cyc, rst_vec());
        step();
        push(cyc, rst_vec());
        PRESET_n = 1'b1;
        step();
        push_idle(cyc, 1'b0);
        spe_i = 1'b1;

        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 1, 0);
        run_frame(2, 1, 1, 0, 0);
        run_frame(2, 1, 1, 1, 0);
        run_frame(0, 0, 0, 0, 1);
        run_frame(2, 1, 1, 1, 1);
        run_frame(1, 1, 0, 1, 2);
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 3);
        run_frame(2, 1, 1, 0, 3);
        run_frame(7, 7, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            gap();
            run_frame(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                      1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
        end

        repeat (4) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
